ws2812_tx_phy: RTL and testbench

//  Serial LED PHY. It drains the 12-bit RGB444 pixel FIFO filled by the zone-frame writer and drives one
//  WS2812-style single-wire data line. Transmission starts on send_start. Each nibble is expanded to 8 bits and

---
 rtl/ws2812_tx_phy.sv | 183 ++++++++++++++++++
 tb/tb_ws2812_tx_phy.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_tx_phy.sv
// WS2812 single-wire LED transmitter: pops RGB444 pixels from a FIFO, sends them as
// GRB888 pulse-width-coded bits with one-pixel prefetch, then holds the line low to latch.
module ws2812_tx_phy #(
  parameter int LED_NUM   = 46,
  parameter int BIT_CYC   = 62,
  parameter int T0H_CYC   = 20,
  parameter int T1H_CYC   = 40,
  parameter int RESET_CYC = 15000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        send_start,
  input  logic        fifo_empty,
  input  logic [11:0] fifo_rdata,
  output logic        fifo_rd,
  output logic        dout,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int BCW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int PCW = $clog2(LED_NUM + 1);
  localparam int LCW = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;
  localparam logic [BCW-1:0] BIT_LAST   = BCW'(BIT_CYC - 1);
  localparam logic [BCW-1:0] T0H        = BCW'(T0H_CYC);
  localparam logic [BCW-1:0] T1H        = BCW'(T1H_CYC);
  localparam logic [PCW-1:0] PIX_MAX    = PCW'(LED_NUM);
  localparam logic [LCW-1:0] LATCH_LAST = LCW'(RESET_CYC - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, LATCH} state_t;

  state_t         state_q, state_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [4:0]     bit_idx_q, bit_idx_d;
  logic [PCW-1:0] pix_cnt_q, pix_cnt_d;
  logic [23:0]    shift_q, shift_d;
  logic [11:0]    pf_q, pf_d;
  logic           pf_valid_q, pf_valid_d;
  logic           rd_pend_q, rd_pend_d;
  logic           uf_q, uf_d;
  logic [LCW-1:0] latch_cnt_q, latch_cnt_d;
  logic           dout_q, dout_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [BCW-1:0] high_len;

  // Nibble n becomes byte {n,n}; wire order is G, R, B.
  function automatic logic [23:0] expand(input logic [11:0] p);
    return {p[7:4], p[7:4], p[3:0], p[3:0], p[11:8], p[11:8]};
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      pix_cnt_q   <= '0;
      shift_q     <= '0;
      pf_q        <= '0;
      pf_valid_q  <= 1'b0;
      rd_pend_q   <= 1'b0;
      uf_q        <= 1'b0;
      latch_cnt_q <= '0;
      dout_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      pix_cnt_q   <= pix_cnt_d;
      shift_q     <= shift_d;
      pf_q        <= pf_d;
      pf_valid_q  <= pf_valid_d;
      rd_pend_q   <= rd_pend_d;
      uf_q        <= uf_d;
      latch_cnt_q <= latch_cnt_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    bit_idx_d   = bit_idx_q;
    pix_cnt_d   = pix_cnt_q;
    shift_d     = shift_q;
    pf_d        = pf_q;
    pf_valid_d  = pf_valid_q;
    rd_pend_d   = rd_pend_q;
    uf_d        = uf_q;
    latch_cnt_d = latch_cnt_q;
    fifo_rd     = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (send_start) begin
          if (fifo_empty) err_d = 1'b1;
          else            state_d = FETCH;
        end
      end
      FETCH: begin
        fifo_rd = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        shift_d    = expand(fifo_rdata);
        bit_idx_d  = 5'd23;
        bit_cnt_d  = '0;
        pix_cnt_d  = PCW'(1);
        pf_valid_d = 1'b0;
        rd_pend_d  = 1'b0;
        uf_d       = 1'b0;
        state_d    = SHIFT;
      end
      SHIFT: begin
        if (rd_pend_q) begin
          pf_d       = fifo_rdata;
          pf_valid_d = 1'b1;
          rd_pend_d  = 1'b0;
        end
        // Fetch the next pixel at the very start of the current one, a full pixel time ahead.
        if (bit_idx_q == 5'd23 && bit_cnt_q == '0 && pix_cnt_q < PIX_MAX) begin
          if (fifo_empty) begin
            uf_d = 1'b1;
          end else begin
            fifo_rd   = 1'b1;
            rd_pend_d = 1'b1;
          end
        end
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 5'd0) begin
            if (pf_valid_q) begin
              shift_d    = expand(pf_q);
              bit_idx_d  = 5'd23;
              pix_cnt_d  = pix_cnt_q + 1'b1;
              pf_valid_d = 1'b0;
            end else begin
              state_d     = LATCH;
              latch_cnt_d = '0;
              err_d       = uf_q;
            end
          end else begin
            bit_idx_d = bit_idx_q - 5'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      LATCH: begin
        if (latch_cnt_q == LATCH_LAST) begin
          latch_cnt_d = '0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end else begin
          latch_cnt_d = latch_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // dout is computed from next-state values so the registered line matches the bit phase.
  always_comb begin
    high_len = shift_d[bit_idx_d] ? T1H : T0H;
    dout_d   = (state_d == SHIFT) && (bit_cnt_d < high_len);
    busy_d   = (state_d != IDLE);
  end

  assign dout = dout_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ws2812_tx_phy.sv
// Bench for ws2812_tx_phy: a FIFO model feeds pixels, a timeline model predicts every
// output cycle by cycle, plus hand-computed frame totals for fixed pixel patterns.
module tb_ws2812_tx_phy;
  localparam int LN   = 3;
  localparam int BC   = 62;
  localparam int T0   = 20;
  localparam int T1   = 40;
  localparam int RC   = 100;
  localparam int PB   = 24 * BC;
  localparam int MEMD = 4096;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        send_start = 1'b0;
  logic        fifo_empty;
  logic [11:0] fifo_rdata;
  logic        fifo_rd, dout, busy, done, err;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  // FIFO model: stimulus owns mem/wp, driver owns rp
  logic [11:0] mem [MEMD];
  int wp = 0;
  int rp;
  logic rd_seen;

  // Frame model
  logic        fr_on = 1'b0;
  int          fr_n = 0;
  int          fr_npix = 0;
  logic        fr_uf = 1'b0;
  logic [11:0] fr_pix [LN];
  int          exp_err_cyc = -1;

  // Monitor totals
  int tot_high = 0, tot_rd = 0, last_done = -1, last_err = -1;

  ws2812_tx_phy #(.LED_NUM(LN), .BIT_CYC(BC), .T0H_CYC(T0), .T1H_CYC(T1), .RESET_CYC(RC)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .send_start(send_start),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_rd   (fifo_rd),
    .dout      (dout),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] grb(input logic [11:0] p);
    return {p[7:4], p[7:4], p[3:0], p[3:0], p[11:8], p[11:8]};
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, act, expv);
    end
  endtask

  initial begin
    rp = 0;
    fifo_empty = 1'b1;
    fifo_rdata = '0;
    forever begin
      @(negedge clk);
      rd_seen = fifo_rd;
      @(posedge clk);
      #1;
      if (rd_seen && rp != wp) begin
        fifo_rdata = mem[rp % MEMD];
        rp++;
      end else begin
        fifo_rdata = 12'($urandom);
      end
      fifo_empty = (rp == wp);
    end
  end

  // Cycle-by-cycle compare against the frame timeline
  initial begin
    int rel, ls, p, b, c;
    logic [23:0] w;
    logic e_dout, e_busy, e_done, e_err, e_rd;
    forever begin
      @(negedge clk);
      e_dout = 0; e_busy = 0; e_done = 0; e_err = 0; e_rd = 0;
      if (rstn && fr_on) begin
        rel = cyc - fr_n;
        ls  = 3 + fr_npix * PB;
        e_busy = (rel >= 1) && (rel < ls + RC);
        e_done = (rel == ls + RC);
        e_err  = fr_uf && (rel == ls);
        e_rd   = (rel == 1) ||
                 ((rel >= 3) && (rel < ls) && ((rel - 3) % PB == 0) && ((rel - 3) / PB + 1 < fr_npix));
        if (rel >= 3 && rel < ls) begin
          p = (rel - 3) / PB;
          b = ((rel - 3) / BC) % 24;
          c = (rel - 3) % BC;
          w = grb(fr_pix[p]);
          e_dout = (c < (w[23 - b] ? T1 : T0));
        end
      end
      if (rstn && cyc == exp_err_cyc) e_err = 1;
      chk("dout", int'(dout), int'(e_dout));
      chk("busy", int'(busy), int'(e_busy));
      chk("done", int'(done), int'(e_done));
      chk("err", int'(err), int'(e_err));
      chk("fifo_rd", int'(fifo_rd), int'(e_rd));
      if (dout) tot_high++;
      if (fifo_rd) tot_rd++;
      if (done) last_done = cyc;
      if (err) last_err = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [11:0] v);
    mem[wp % MEMD] = v;
    wp++;
  endtask

  int st_n, b_high, b_rd, b_err;

  task automatic do_start();
    int avail;
    avail = wp - rp;
    st_n = cyc; b_high = tot_high; b_rd = tot_rd; b_err = last_err;
    send_start = 1'b1;
    if (avail == 0) begin
      exp_err_cyc = cyc + 1;
    end else begin
      fr_npix = (avail < LN) ? avail : LN;
      fr_uf = (avail < LN);
      for (int k = 0; k < fr_npix; k++) fr_pix[k] = mem[(rp + k) % MEMD];
      fr_n = cyc;
      fr_on = 1'b1;
    end
    tick();
    send_start = 1'b0;
  endtask

  task automatic wait_frame(input bit extra);
    int ls;
    ls = 3 + fr_npix * PB;
    while (cyc - fr_n <= ls + RC) begin
      if (extra && (cyc - fr_n) >= 1 && (cyc - fr_n) <= ls + RC - 2 && $urandom_range(0, 199) == 0)
        send_start = 1'b1;
      else
        send_start = 1'b0;
      tick();
    end
    send_start = 1'b0;
    fr_on = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    // Full frame of 0xF0F: each pixel 16 ones (40 high) + 8 zeros (20 high) = 800
    for (int k = 0; k < LN; k++) push(12'hF0F);
    tick();
    do_start();
    wait_frame(1'b0);
    chk("t1_high", tot_high - b_high, 2400);
    chk("t1_pops", tot_rd - b_rd, 3);
    chk("t1_done_lat", last_done - st_n, 4567);
    chk("t1_no_err", last_err, b_err);

    // Single 0x080 pixel: G=0x88 -> 2 ones, 22 zeros; underflow after it
    push(12'h080);
    tick();
    do_start();
    wait_frame(1'b0);
    chk("t2_high", tot_high - b_high, 520);
    chk("t2_pops", tot_rd - b_rd, 1);
    chk("t2_err_lat", last_err - st_n, 1491);
    chk("t2_done_lat", last_done - st_n, 1591);

    // Empty FIFO start
    do_start();
    repeat (4) tick();
    chk("t3_err_lat", last_err - st_n, 1);
    chk("t3_pops", tot_rd - b_rd, 0);
    chk("t3_high", tot_high - b_high, 0);

    // Two entries of black, frame of LN=3 underflows after two pixels
    push(12'h000);
    push(12'h000);
    tick();
    do_start();
    wait_frame(1'b1);
    chk("t4_high", tot_high - b_high, 960);
    chk("t4_err_lat", last_err - st_n, 2979);
    chk("t4_done_lat", last_done - st_n, 3079);

    // Reset in the high phase of bit 4 of an all-ones pixel, with starts while busy
    for (int k = 0; k < LN; k++) push(12'hFFF);
    tick();
    do_start();
    while (cyc - fr_n < 3 + 4 * BC + 5) begin
      send_start = ($urandom_range(0, 9) == 0);
      tick();
    end
    send_start = 1'b0;
    chk("pre_rst_dout", int'(dout), 1);
    chk("pre_rst_busy", int'(busy), 1);
    #1;
    rstn = 1'b0;
    fr_on = 1'b0;
    exp_err_cyc = -1;
    #1;
    chk("rst_dout", int'(dout), 0);
    chk("rst_busy", int'(busy), 0);
    tick();
    tick();
    rstn = 1'b1;
    push(12'h5A3);
    push(12'hC71);
    tick();
    do_start();
    wait_frame(1'b1);
    chk("t5_pops", tot_rd - b_rd, 3);
    chk("t5_done_lat", last_done - st_n, 4567);

    // Randomized frames, including empty and underflow cases
    for (int it = 0; it < 7; it++) begin
      n = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) push(12'($urandom));
      repeat ($urandom_range(1, 3)) tick();
      do_start();
      if (fr_on) wait_frame(1'b1);
      else repeat (4) tick();
      exp_err_cyc = -1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
